// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: shared register-file constants and helpers for the writeback arbiter
package rf_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_ZERO  = 0;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1) % n;
    endfunction

    // Register 0 is hardwired, so it never gets a scoreboard bit.
    function automatic logic [RF_NREGS-1:0] reg_mask(input logic [31:0] a);
        return (a < RF_NREGS && a != RF_ZERO) ? RF_NREGS'(1) << a : '0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   winner
);

    function automatic int slot(input logic [PW-1:0] p, input int k);
        return (int'(p) + k) % NREQ;
    endfunction

    // Walk from the farthest slot back to ptr so the closest valid one lands last.
    always_comb begin
        grant  = '0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[slot(ptr, k)]) begin
                grant               = '0;
                grant[slot(ptr, k)] = 1'b1;
                winner              = PW'(slot(ptr, k));
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin sharing of the reg_file write port plus busy scoreboard
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                wr,
    output logic [AW-1:0]       addr3,
    output logic [DW-1:0]       data3,
    output logic [RF_NREGS-1:0] busy
);

    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       winner;
    logic [NREQ-1:0]     grant;
    logic                wr_q;
    logic                acc;
    logic [AW-1:0]       waddr;
    logic [DW-1:0]       wdata;
    logic [RF_NREGS-1:0] set_mask;
    logic [RF_NREGS-1:0] clr_mask;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    // A write registered just before reset is masked so it never lands in reg_file.
    always_comb begin
        req_ready = rst ? '0 : grant;
        acc       = |req_ready;
        waddr     = req_addr[winner*AW +: AW];
        wdata     = req_data[winner*DW +: DW];
        wr        = wr_q && !rst;
        set_mask  = iss_valid ? reg_mask(32'(iss_addr)) : '0;
        clr_mask  = wr ? reg_mask(32'(addr3)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= 1'b0;
            addr3  <= '0;
            data3  <= '0;
            busy   <= '0;
            rr_ptr <= '0;
        end else begin
            wr_q <= acc && waddr != AW'(RF_ZERO);
            busy <= (busy & ~clr_mask) | set_mask;
            if (acc) begin
                addr3  <= waddr;
                data3  <= wdata;
                rr_ptr <= PW'(wrap_inc(int'(winner), NREQ));
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: vector table plus scoreboard for the writeback arbiter
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 2;

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        iv;
        logic [4:0]  ia;
        logic [1:0]  er;
    } vec_t;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [31:0] busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr        (wr),
        .addr3     (addr3),
        .data3     (data3),
        .busy      (busy)
    );

    logic [31:0] rf [32];
    always @(posedge clk) if (wr) rf[addr3] <= data3;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        m;
    int          m_ptr = 0;
    logic [31:0] m_busy = '0;
    vec_t        vq[$];

    function automatic vec_t mk(input logic r, input logic [1:0] rv,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic iv, input logic [4:0] ia, input logic [1:0] er);
        vec_t v;
        v.rst = r; v.rv = rv; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.iv = iv; v.ia = ia; v.er = er;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        req_valid = v.rv;
        req_addr  = {v.a1, v.a0};
        req_data  = {v.d1, v.d0};
        iss_valid = v.iv;
        iss_addr  = v.ia;
    endtask

    task automatic tick(input logic [1:0] er);
        exp_t        e;
        int          win;
        logic [31:0] nb;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", busy, m_busy);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr", 32'(wr), 32'(e.w && !rst));
            chk("addr3", 32'(addr3), 32'(e.a));
            chk("data3", data3, e.d);
        end
        if (rst) begin
            m_ptr  = 0;
            m_busy = '0;
            m.w = 1'b0; m.a = '0; m.d = '0;
        end else begin
            nb = m_busy;
            if (m.w) nb[m.a] = 1'b0;
            if (iss_valid && iss_addr != 0) nb[iss_addr] = 1'b1;
            m_busy = nb;
            win = -1;
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            m.w = 1'b0;
            if (win >= 0) begin
                m.a   = req_addr[win*5 +: 5];
                m.d   = req_data[win*32 +: 32];
                m.w   = m.a != 0;
                m_ptr = (win + 1) % NREQ;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        m.w = 1'b0; m.a = '0; m.d = '0;
        // reset, then single write to r10
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 10, 2'b00));
        vq.push_back(mk(0, 2'b01, 10, 32'h0000ffff, 0, 0, 0, 0, 2'b01));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        // contention from a fresh pointer
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vq.push_back(mk(0, 2'b11, 14, 32'hff00, 31, 32'haaaa, 0, 0, 2'b01));
        vq.push_back(mk(0, 2'b10, 14, 32'hff00, 31, 32'haaaa, 0, 0, 2'b10));
        vq.push_back(mk(0, 2'b11, 14, 32'hff00, 31, 32'haaaa, 0, 0, 2'b01));
        vq.push_back(mk(0, 2'b10, 14, 32'hff00, 31, 32'haaaa, 0, 0, 2'b10));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        // register 0
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00));
        vq.push_back(mk(0, 2'b10, 0, 0, 0, 32'h8888, 0, 0, 2'b10));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        // same-edge set and clear of r14
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 14, 2'b00));
        vq.push_back(mk(0, 2'b01, 14, 32'h5555, 0, 0, 0, 0, 2'b01));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 14, 2'b00));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        // pointer at 1 wraps to requester 0
        vq.push_back(mk(0, 2'b01, 3, 32'hcafe, 0, 0, 0, 0, 2'b01));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));

        foreach (vq[i]) begin
            drive(vq[i]);
            tick(vq[i].er);
        end

        chk("rf[10]", rf[10], 32'h0000ffff);
        chk("rf[14]", rf[14], 32'h5555);
        chk("rf[31]", rf[31], 32'haaaa);
        chk("rf[3]", rf[3], 32'hcafe);
        chk("rf[0]", rf[0], 32'h0);
        chk("busy14", 32'(busy[14]), 32'h1);

        // reset the cycle after an accept to r31
        drive(mk(0, 2'b10, 0, 0, 31, 32'hdead, 1, 31, 2'b10));
        tick(2'b10);
        drive(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        tick(2'b00);
        drive(mk(0, 2'b11, 7, 32'h1, 8, 32'h2, 0, 0, 2'b01));
        tick(2'b01);
        drive(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        tick(2'b00);
        tick(2'b00);
        chk("rf[31] after reset", rf[31], 32'haaaa);
        chk("rf[7]", rf[7], 32'h1);
        chk("busy after reset", busy, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
